// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian word image from the host link into instruction memory
// under a front-end stall, then pulses the core reset. Define LOADER_CSUM_EN for a trailing checksum byte.
module program_loader #(
  parameter int ADDR_W     = 32,
  parameter int MAX_WORDS  = 1024,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              dbg_we,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_instr,
  output logic              core_stall,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_RUN_RST, S_CSUM} state_t;

`ifdef LOADER_CSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_RUN_RST;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_asm;
  logic [31:0]         r_len;
  logic [ADDR_W-1:0]   r_index;
  logic [RCNT_W-1:0]   r_rcnt;
  logic [ADDR_W-1:0]   r_dbg_addr;
  logic [31:0]         r_dbg_instr;
  logic                r_done;
  logic                r_err;
  logic                w_acc;
  logic                w_last_byte;
  logic                w_last_word;
  logic [31:0]         w_word;
`ifdef LOADER_CSUM_EN
  logic [7:0]          r_csum;
`endif

  assign w_acc       = rx_valid & rx_ready;
  assign w_last_byte = w_acc && (r_bcnt == 2'd3);
  // The 4th byte is used straight off the bus so the word is ready the cycle it completes.
  assign w_word      = {rx_data, r_asm};
  assign w_last_word = (32'(r_index + ADDR_W'(1)) == r_len);

  assign dbg_addr  = r_dbg_addr;
  assign dbg_instr = r_dbg_instr;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    rx_ready    = 1'b0;
    dbg_we      = 1'b0;
    core_rst_n  = 1'b1;
    busy        = (r_state != S_IDLE);
    core_stall  = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LEN;
      S_LEN: begin
        rx_ready = 1'b1;
        if (w_last_byte) begin
          if (w_word == 32'd0)                  w_state_nxt = S_POST;
          else if (w_word > 32'(MAX_WORDS))     w_state_nxt = S_IDLE;
          else                                  w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (w_last_byte) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        dbg_we      = 1'b1;
        w_state_nxt = w_last_word ? S_POST : S_DATA;
      end
      S_RUN_RST: begin
        core_rst_n = 1'b0;
        if (r_rcnt == RCNT_W'(RST_CYCLES - 1)) w_state_nxt = S_IDLE;
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (w_acc) w_state_nxt = (rx_data == r_csum) ? S_RUN_RST : S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_bcnt      <= '0;
      r_asm       <= '0;
      r_len       <= '0;
      r_index     <= '0;
      r_rcnt      <= '0;
      r_dbg_addr  <= '0;
      r_dbg_instr <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef LOADER_CSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && start) begin
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_bcnt  <= '0;
        r_index <= '0;
        r_len   <= '0;
`ifdef LOADER_CSUM_EN
        r_csum  <= '0;
`endif
      end
      if (w_acc) begin
        r_bcnt <= r_bcnt + 2'd1;
        case (r_bcnt)
          2'd0:    r_asm[7:0]   <= rx_data;
          2'd1:    r_asm[15:8]  <= rx_data;
          2'd2:    r_asm[23:16] <= rx_data;
          default: ;
        endcase
`ifdef LOADER_CSUM_EN
        if (r_state == S_DATA) r_csum <= r_csum + rx_data;
`endif
      end
      if (r_state == S_LEN && w_last_byte) r_len <= w_word;
      if (r_state == S_DATA && w_last_byte) begin
        r_dbg_addr  <= r_index;
        r_dbg_instr <= w_word;
      end
      if (r_state == S_WRITE) r_index <= r_index + ADDR_W'(1);
      r_rcnt <= (r_state == S_RUN_RST) ? r_rcnt + RCNT_W'(1) : '0;
      // Leaving a busy state for IDLE is a success only from the reset pulse; anything else aborts.
      if (r_state == S_RUN_RST && w_state_nxt == S_IDLE) r_done <= 1'b1;
      if (r_state != S_RUN_RST && r_state != S_IDLE && w_state_nxt == S_IDLE) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a stream model builds host frames and expected writes; per-scenario tasks check results.
module tb_program_loader;
  localparam int AW = 32, MAXW = 1024, RSTC = 4;

  logic          clk = 1'b0, nrst = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, dbg_we, core_stall, core_rst_n, busy, done, err;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_instr;

  program_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW), .RST_CYCLES(RSTC)) dut (
    .clk(clk), .nrst(nrst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
    .core_stall(core_stall), .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  logic [63:0] wr_q[$];
  int          wr_t[$];
  int          rst_low, rdy_in_wr, stall_bad;
  logic [7:0]  stream[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) if (nrst) begin
    if (dbg_we) begin
      wr_q.push_back({dbg_addr, dbg_instr});
      wr_t.push_back(cyc);
      if (rx_ready) rdy_in_wr++;
    end
    if (!core_rst_n) begin
      rst_low++;
      if (!core_stall) stall_bad++;
    end
  end

  // Reference frame: 4-byte LE length, then words LE (only if length is legal), then optional checksum.
  task automatic build_stream(input logic [31:0] n, input logic [31:0] w[$], input bit bad_sum);
    logic [7:0] sum;
    sum = 8'h00;
    stream.delete();
    for (int b = 0; b < 4; b++) stream.push_back(8'((n >> (8 * b)) & 32'hFF));
    if (n <= MAXW) begin
      for (int k = 0; k < w.size(); k++)
        for (int b = 0; b < 4; b++) begin
          stream.push_back(8'((w[k] >> (8 * b)) & 32'hFF));
          sum = sum + 8'((w[k] >> (8 * b)) & 32'hFF);
        end
`ifdef LOADER_CSUM_EN
      stream.push_back(bad_sum ? sum + 8'd1 : sum);
`endif
    end
  endtask

  task automatic do_load(input bit gaps, input bit poke, output bit ok, output int t0);
    int  i, lim;
    bit  xfer;
    wr_q.delete(); wr_t.delete();
    rst_low = 0; rdy_in_wr = 0; stall_bad = 0;
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    i = 0; lim = 0;
    while (i < stream.size() && lim < 5000) begin
      rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      rx_data  = rx_valid ? stream[i] : 8'($urandom);
      start    = poke && busy && ($urandom_range(0, 3) == 0);
      xfer     = rx_valid && rx_ready;
      @(negedge clk);
      if (xfer) i++;
      lim++;
    end
    rx_valid = 1'b0; start = 1'b0;
    lim = 0;
    while (busy && lim < 200) begin @(negedge clk); lim++; end
    ok = !busy && (i == stream.size());
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({rx_ready, dbg_we, dbg_addr, dbg_instr, core_stall, core_rst_n, busy, done, err} !==
        {2'b00, 64'd0, 5'b01000}) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h instr=%h stall=%b rstn=%b busy=%b done=%b err=%b, want all idle with rstn=1",
               rx_ready, dbg_we, dbg_addr, dbg_instr, core_stall, core_rst_n, busy, done, err);
    end
  endtask

  task automatic test_two_word(input bit bad_sum);
    logic [31:0] w[$];
    bit ok; int t0;
    w = '{32'h00000013, 32'h00100093};
    build_stream(32'd2, w, bad_sum);
    do_load(1'b0, 1'b0, ok, t0);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL two_word_finish: ok=%b want 1", ok); end
    n_cmp++; if (wr_q.size() !== 2) begin n_err++; $display("FAIL two_word_count: got %0d writes want 2", wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== {32'd0, 32'h00000013}) begin n_err++; $display("FAIL two_word_w0: got %h want 0/00000013", wr_q[0]); end
      n_cmp++; if (wr_q[1] !== {32'd1, 32'h00100093}) begin n_err++; $display("FAIL two_word_w1: got %h want 1/00100093", wr_q[1]); end
    end
    n_cmp++; if (rst_low !== (bad_sum ? 0 : RSTC)) begin n_err++; $display("FAIL two_word_rst_len: got %0d low cycles want %0d", rst_low, bad_sum ? 0 : RSTC); end
    n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL two_word_stall_in_rst: got %0d unstalled reset cycles want 0", stall_bad); end
    n_cmp++; if ({done, err, core_stall, core_rst_n} !== {~bad_sum, bad_sum, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL two_word_status: got done=%b err=%b stall=%b rstn=%b want done=%b err=%b stall=0 rstn=1",
                        done, err, core_stall, core_rst_n, ~bad_sum, bad_sum);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] w[$];
    w = '{32'hDEADBEEF, 32'h12345678};
    build_stream(32'd2, w, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) begin rx_valid = 1'b1; rx_data = stream[i]; @(negedge clk); end
    rx_valid = 1'b0;
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_data: rx_ready=%b want 1", rx_ready); end
    #2 nrst = 1'b0;
    #1 test_reset();
    @(negedge clk); nrst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, rx_ready} !== 2'b00) begin n_err++; $display("FAIL after_release: busy=%b rdy=%b want 0 0", busy, rx_ready); end
  endtask

  task automatic test_zero_len;
    logic [31:0] w[$];
    bit ok; int t0;
    w.delete();
    build_stream(32'd0, w, 1'b0);
    do_load(1'b1, 1'b0, ok, t0);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL zero_finish: ok=%b want 1", ok); end
    n_cmp++; if (wr_q.size() !== 0) begin n_err++; $display("FAIL zero_writes: got %0d want 0", wr_q.size()); end
    n_cmp++; if (rst_low !== RSTC) begin n_err++; $display("FAIL zero_rst_len: got %0d want %0d", rst_low, RSTC); end
    n_cmp++; if ({done, err} !== 2'b10) begin n_err++; $display("FAIL zero_status: done=%b err=%b want 1 0", done, err); end
  endtask

  task automatic test_oversize;
    logic [31:0] w[$];
    bit ok; int t0;
    w.delete();
    build_stream(32'd1025, w, 1'b0);
    do_load(1'b0, 1'b0, ok, t0);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL over_finish: ok=%b want 1", ok); end
    n_cmp++; if ({wr_q.size() == 0, rst_low == 0} !== 2'b11) begin
      n_err++; $display("FAIL over_activity: got %0d writes %0d reset cycles want 0 0", wr_q.size(), rst_low);
    end
    n_cmp++; if ({done, err, core_stall, busy} !== 4'b0100) begin
      n_err++; $display("FAIL over_status: done=%b err=%b stall=%b busy=%b want 0 1 0 0", done, err, core_stall, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w[$];
    bit ok; int t0;
    w = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003};
    build_stream(32'd3, w, 1'b0);
    do_load(1'b0, 1'b0, ok, t0);
    n_cmp++; if (wr_t.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d writes want 3", wr_t.size()); end
    else begin
      // start edge + 4 header + 4 data bytes => first strobe visible 9 edges after start was raised
      n_cmp++; if (wr_t[0] - t0 !== 9) begin n_err++; $display("FAIL b2b_first_latency: got %0d cycles want 9", wr_t[0] - t0); end
      for (int k = 1; k < 3; k++) begin
        n_cmp++; if (wr_t[k] - wr_t[k-1] !== 5) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d cycles want 5", k, wr_t[k] - wr_t[k-1]); end
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] w[$];
    bit ok; int t0, n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      w.delete();
      for (int k = 0; k < n; k++) w.push_back($urandom);
      build_stream(32'(n), w, 1'b0);
      do_load(1'b1, 1'b1, ok, t0);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rand%0d_finish: ok=%b want 1", r, ok); end
      n_cmp++; if (wr_q.size() !== n) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", r, wr_q.size(), n); end
      else for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (wr_q[k] !== {32'(k), w[k]}) begin n_err++; $display("FAIL rand%0d_w%0d: got %h want %h", r, k, wr_q[k], {32'(k), w[k]}); end
      end
      n_cmp++; if (rdy_in_wr !== 0) begin n_err++; $display("FAIL rand%0d_rdy_in_write: got %0d want 0", r, rdy_in_wr); end
      n_cmp++; if ({done, err, rst_low} !== {2'b10, 32'(RSTC)}) begin
        n_err++; $display("FAIL rand%0d_status: done=%b err=%b rst=%0d want 1 0 %0d", r, done, err, rst_low, RSTC);
      end
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand%0d_stray_start: busy=%b want 0", r, busy); end
    end
  endtask

  initial begin
    #2 test_reset();
    @(negedge clk); nrst = 1'b1;
    @(negedge clk);
    test_two_word(1'b0);
    test_reset_mid();
    test_zero_len();
    test_oversize();
    test_back_to_back();
    test_random();
`ifdef LOADER_CSUM_EN
    test_two_word(1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Debug-side writer that loads a program image into the core's instruction memory over its debug write port (write strobe, word address, instruction word).
- Consumes a byte stream from the host link via valid/ready; frame = length header followed by little-endian instruction words.
- Holds the front end stalled while loading, then pulses a core reset so fetch restarts at PC 0.
- Sits between the host byte receiver and the instruction-memory debug port.

Parameters:
- ADDR_W, 32, width of the word address driven to instruction memory. PC increments by 1 per instruction, so addresses are word indices.
- MAX_WORDS, 1024, largest accepted program length in words.
- RST_CYCLES, 4, number of cycles core_rst_n is held low after a successful load (≥1).

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; ignored while busy.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- dbg_we  output  1  instruction-memory debug write strobe.
- dbg_addr  output  ADDR_W  word address of write.
- dbg_instr  output  32  instruction word to write.
- core_stall  output  1  freezes front-end fetch while high.
- core_rst_n  output  1  active-low core reset pulse.
- busy  output  1  load in progress (any state other than IDLE).
- done  output  1  last load completed successfully; level, cleared on next accepted start.
- err  output  1  last load aborted; level, cleared on next accepted start.

Behaviour:
- Reset (async, nrst=0), all outputs forced: rx_ready=0, dbg_we=0, dbg_addr=0, dbg_instr=0, core_stall=0, core_rst_n=1, busy=0, done=0, err=0.
  - State returns to IDLE; byte counter, word index, length and assembly register cleared.
  - Reset mid-load abandons the load; words already written stay in memory.
- A byte transfer occurs on a rising edge with rx_valid & rx_ready.
- FSM states: IDLE, LEN, DATA, WRITE, RUN_RST.
- IDLE
  - rx_ready=0.
  - On start: clear done/err, set core_stall=1, clear counters, go to LEN.
- LEN
  - rx_ready=1; accept 4 bytes, little-endian, into N (32 bit).
  - After the 4th byte:
    - N=0: go to RUN_RST.
    - N>MAX_WORDS: set err=1, core_stall=0, go to IDLE; no write is issued.
    - Otherwise: go to DATA.
- DATA
  - rx_ready=1; accept 4 bytes, first byte into [7:0], last into [31:24].
  - After the 4th byte, go to WRITE.
- WRITE (exactly one cycle)
  - rx_ready=0, dbg_we=1, dbg_addr=index, dbg_instr=assembled word.
  - Next cycle: index+1, dbg_we=0.
  - If index+1==N go to RUN_RST, else go to DATA.
  - dbg_addr/dbg_instr hold their last values when dbg_we=0.
- RUN_RST
  - core_rst_n=0 for RST_CYCLES cycles, core_stall stays 1.
  - Then core_rst_n=1, core_stall=0, done=1, go to IDLE.
- Latency:
  - The first data word's dbg_we occurs the cycle after its 4th byte is accepted.
  - Minimum 5 cycles per word with back-to-back bytes.
- rx_valid low stalls progress indefinitely; there is no timeout.
- start while busy is ignored. A start in the same cycle the FSM enters IDLE is also ignored.
- The index counter is ADDR_W bits. Because N≤MAX_WORDS, it never wraps.
- Bytes arriving while in IDLE are not accepted (rx_ready=0).

Optional Feature:
- LOADER_CSUM_EN defined:
  - After the last data word, a CSUM state accepts one extra byte with rx_ready=1.
  - That byte is compared with the 8-bit modulo sum of all data bytes; the header is excluded.
  - Match: go to RUN_RST.
  - Mismatch: err=1, core_stall=0, no reset pulse, go to IDLE.
  - N=0 still expects the checksum byte, which must be 0x00.
- Undefined: no CSUM state; behaviour exactly as above.

Test Plan:
- Reset values: assert nrst low mid-DATA → all outputs at reset values immediately; after release, busy=0 and rx_ready=0.
- Two-word load: start, bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 → dbg_we pulses with (addr 0, 0x00000013) then (addr 1, 0x00100093), each one cycle long.
  - Then core_rst_n low for 4 cycles, then core_stall=0 and done=1.
- Zero length: header 00 00 00 00 → no dbg_we, reset pulse, done=1.
  - With LOADER_CSUM_EN, this also needs checksum byte 00.
- Oversize: header 01 04 00 00 (1025) → err=1, core_stall=0, no dbg_we, busy=0.
- Backpressure/ignore: rx_valid toggled randomly and start pulsed mid-load → words written are identical, start has no effect, rx_ready=0 during WRITE cycles.
- LOADER_CSUM_EN: two-word image above with checksum 0xB6 → done=1; with checksum 0xB7 → err=1, no reset pulse.
